// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - accepts a 16-bit value, captures its BCD digits and scans a 4-digit 7-seg display
// Optional: define SEG_LZ_BLANK_EN to blank leading zeros on digits 0..2.
module seg_scan_ctrl #(
    parameter int CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        val_valid,
    input  logic [15:0] val_data,
    output logic        val_ready,
    output logic [15:0] bcd_bin,
    input  logic [3:0]  bcd_in [0:3],
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        overflow
);

    typedef enum logic {SHOW, CONV} state_t;

    localparam int         PRE_W     = 21;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
`ifdef SEG_LZ_BLANK_EN
    localparam logic [6:0] SEG_RST   = SEG_BLANK;
`else
    localparam logic [6:0] SEG_RST   = 7'b1000000;
`endif

    state_t           state, state_nx;
    logic             accept;
    logic [PRE_W-1:0] pre;
    logic             tick;
    logic [1:0]       idx;
    logic [3:0]       dig [0:3];
    logic [3:0]       cur;
    logic             blank;
    logic [3:0]       an_nx;
    logic [6:0]       seg_nx;
`ifdef SEG_LZ_BLANK_EN
    logic [3:0]       lz;
`endif

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        state_nx  = state;
        val_ready = 1'b0;
        accept    = 1'b0;
        case (state)
            SHOW: begin
                val_ready = 1'b1;
                if (val_valid) begin
                    accept   = 1'b1;
                    state_nx = CONV;
                end
            end
            CONV: state_nx = SHOW;
        endcase
    end

    assign tick = (pre == PRE_MAX);

    // Next display slot is derived from the current idx/dig; registering it gives the one-cycle lag.
    always_comb begin
        cur   = dig[idx];
        blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
        lz[0] = (dig[0] == 4'd0);
        lz[1] = lz[0] && (dig[1] == 4'd0);
        lz[2] = lz[1] && (dig[2] == 4'd0);
        lz[3] = 1'b0;
        blank = lz[idx];
`endif
        if (overflow)
            seg_nx = SEG_DASH;
        else if (blank)
            seg_nx = SEG_BLANK;
        else
            seg_nx = decode(cur);
        an_nx = ~(4'b0001 << idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SHOW;
            bcd_bin  <= 16'd0;
            overflow <= 1'b0;
            pre      <= '0;
            idx      <= 2'd0;
            for (int i = 0; i < 4; i++) dig[i] <= 4'd0;
            an_n     <= 4'b1110;
            seg_n    <= SEG_RST;
        end else begin
            state <= state_nx;
            pre   <= tick ? '0 : pre + 1'b1;
            if (tick) idx <= idx + 2'd1;
            if (accept) begin
                bcd_bin  <= val_data;
                overflow <= (val_data > 16'd9999);
            end
            if (state == CONV) begin
                for (int i = 0; i < 4; i++) dig[i] <= bcd_in[i];
            end
            an_n  <= an_nx;
            seg_n <= seg_nx;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl with a cycle-count display model
module tb_seg_scan_ctrl;

    localparam int N = 4;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S9 = 7'b0010000, SD = 7'b0111111, SB = 7'b1111111;
`ifdef SEG_LZ_BLANK_EN
    localparam logic [6:0] SR = SB;
    localparam logic [6:0] L0 = SB;
`else
    localparam logic [6:0] SR = S0;
    localparam logic [6:0] L0 = S0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        val_valid = 1'b0;
    logic [15:0] val_data = 16'd0;
    logic        val_ready, overflow;
    logic [15:0] bcd_bin;
    logic [3:0]  bcd_in [0:3];
    logic [3:0]  an_n;
    logic [6:0]  seg_n;

    logic        val_ready1, overflow1;
    logic [15:0] bcd_bin1;
    logic [3:0]  bcd_in1 [0:3];
    logic [3:0]  an_n1;
    logic [6:0]  seg_n1;

    int checks = 0;
    int failures = 0;
    logic check_en = 1'b0;

    always #5 clk = ~clk;

    // Behavioural bin_to_bcd feeding each instance.
    assign bcd_in[0]  = 4'((bcd_bin / 16'd1000) % 16'd10);
    assign bcd_in[1]  = 4'((bcd_bin / 16'd100) % 16'd10);
    assign bcd_in[2]  = 4'((bcd_bin / 16'd10) % 16'd10);
    assign bcd_in[3]  = 4'(bcd_bin % 16'd10);
    assign bcd_in1[0] = 4'((bcd_bin1 / 16'd1000) % 16'd10);
    assign bcd_in1[1] = 4'((bcd_bin1 / 16'd100) % 16'd10);
    assign bcd_in1[2] = 4'((bcd_bin1 / 16'd10) % 16'd10);
    assign bcd_in1[3] = 4'(bcd_bin1 % 16'd10);

    seg_scan_ctrl #(.CLK_DIV(N)) dut (
        .clk(clk), .rst_n(rst_n), .val_valid(val_valid), .val_data(val_data),
        .val_ready(val_ready), .bcd_bin(bcd_bin), .bcd_in(bcd_in),
        .an_n(an_n), .seg_n(seg_n), .overflow(overflow)
    );

    seg_scan_ctrl #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .val_valid(val_valid), .val_data(val_data),
        .val_ready(val_ready1), .bcd_bin(bcd_bin1), .bcd_in(bcd_in1),
        .an_n(an_n1), .seg_n(seg_n1), .overflow(overflow1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Glyph for display position pos of decimal value v.
    function automatic logic [6:0] glyph(input int v, input logic ovf, input int pos);
        int p [4] = '{1000, 100, 10, 1};
        if (ovf) return SD;
`ifdef SEG_LZ_BLANK_EN
        if (pos < 3 && (v / p[pos]) == 0) return SB;
`endif
        case ((v / p[pos]) % 10)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Model: slot from edge count since reset, displayed value lags the accept by two edges.
    int         m_cnt = 0;
    int         m_idx;
    logic       m_busy = 1'b0;
    int         m_bin = 0;
    logic       m_ovf = 1'b0;
    int         m_digval = 0;
    logic       exp_ready = 1'b1;
    logic [3:0] exp_an = 4'b1110;
    logic [6:0] exp_seg = SR;

    assign m_idx = (m_cnt / N) % 4;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt     <= 0;
            m_busy    <= 1'b0;
            m_bin     <= 0;
            m_ovf     <= 1'b0;
            m_digval  <= 0;
            exp_ready <= 1'b1;
            exp_an    <= 4'b1110;
            exp_seg   <= SR;
        end else begin
            exp_an  <= ~(4'b0001 << m_idx);
            exp_seg <= glyph(m_digval, m_ovf, m_idx);
            m_cnt   <= m_cnt + 1;
            if (m_busy) begin
                m_digval  <= m_bin;
                m_busy    <= 1'b0;
                exp_ready <= 1'b1;
            end else if (val_valid) begin
                m_bin     <= int'(val_data);
                m_ovf     <= (val_data > 16'd9999);
                m_busy    <= 1'b1;
                exp_ready <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("m_ready", {31'd0, val_ready}, {31'd0, exp_ready});
            chk("m_bcd_bin", {16'd0, bcd_bin}, m_bin);
            chk("m_overflow", {31'd0, overflow}, {31'd0, m_ovf});
            chk("m_an_n", {28'd0, an_n}, {28'd0, exp_an});
            chk("m_seg_n", {25'd0, seg_n}, {25'd0, exp_seg});
        end
    end

    task automatic send(input logic [15:0] v);
        int t = 0;
        @(negedge clk);
        val_valid = 1'b1;
        val_data  = v;
        while (!val_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=val_ready_low required=val_ready_high");
        end
        @(negedge clk);
        val_valid = 1'b0;
        chk("bcd_bin_after_accept", {16'd0, bcd_bin}, {16'd0, v});
    endtask

    task automatic frame(input string name, input logic [6:0] e0, e1, e2, e3);
        logic [6:0] e [4];
        int t = 0;
        e = '{e0, e1, e2, e3};
        while (an_n !== 4'b0111 && t < 64) begin @(negedge clk); t++; end
        while (an_n !== 4'b1110 && t < 64) begin @(negedge clk); t++; end
        if (t >= 64) begin
            checks++;
            failures++;
            $display("FAIL %s_align actual=no_frame_start required=an_n_1110", name);
        end else begin
            for (int k = 0; k < 4 * N; k++) begin
                chk({name, "_an"}, {28'd0, an_n}, {28'd0, ~(4'b0001 << (k / N))});
                chk({name, "_seg"}, {25'd0, seg_n}, {25'd0, e[k / N]});
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [3:0] rs;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, val_ready}, 32'd1);
        chk("rst_an", {28'd0, an_n}, 32'h0000000e);
        chk("rst_seg", {25'd0, seg_n}, {25'd0, SR});
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_bin", {16'd0, bcd_bin}, 32'd0);
        rst_n = 1'b1;
        check_en = 1'b1;

        send(16'd1234);
        frame("f1234", S1, S2, S3, S4);

        send(16'd10000);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        frame("f10000", SD, SD, SD, SD);
        send(16'd9999);
        chk("ovf_clr", {31'd0, overflow}, 32'd0);
        frame("f9999", S9, S9, S9, S9);

        @(negedge clk);
        val_valid = 1'b1;
        val_data  = 16'd5678;
        rs[3] = val_ready;
        @(negedge clk);
        rs[2] = val_ready;
        val_data = 16'd42;
        @(negedge clk);
        rs[1] = val_ready;
        @(negedge clk);
        rs[0] = val_ready;
        val_valid = 1'b0;
        chk("b2b_ready_seq", {28'd0, rs}, 32'h0000000a);
        chk("b2b_bin", {16'd0, bcd_bin}, 32'd42);
        frame("f42", L0, L0, S4, S2);

        send(16'd305);
        frame("f305", L0, S3, S0, S5);

        send(16'd305);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'd0, val_ready}, 32'd1);
        chk("arst_an", {28'd0, an_n}, 32'h0000000e);
        chk("arst_seg", {25'd0, seg_n}, {25'd0, SR});
        chk("arst_ovf", {31'd0, overflow}, 32'd0);
        chk("arst_bin", {16'd0, bcd_bin}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("restart_an", {28'd0, an_n}, 32'h0000000e);
            chk("restart_seg", {25'd0, seg_n}, {25'd0, SR});
            chk("div1_an", {28'd0, an_n1}, {28'd0, ~(4'b0001 << k)});
        end
        frame("fzero", L0, L0, L0, S0);

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
